pwr_dn_seq: RTL and testbench



---
 rtl/pwr_dn_seq.sv | 203 ++++++++++++++++++++
 tb/tb_pwr_dn_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwr_dn_seq.sv
// ---------------------------------------------------------------------------
// pwr_dn_seq
// Ordered power-down sequencer for the node rails. On an orderly request the
// rails are removed in reverse bring-up order (host PERST, NODEx, devices,
// AUX fan) and each monitored PWRGD is given a bounded time to fall. A fault
// request bypasses the ordering and drops every gate in one cycle.
//
// Build option: define PWR_DN_FAN_KEEP_EN to keep the AUX fan rail enabled
// after an orderly power-down (the sequence skips ST_FAN_OFF). A fault still
// drops the fan gate.
// ---------------------------------------------------------------------------
module pwr_dn_seq #(
  parameter logic [15:0] PERST_DLY_MS = 16'd10,
  parameter logic [15:0] DEV_DLY_MS   = 16'd20,
  parameter logic [15:0] PGOOD_TMO_MS = 16'd150
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iTick_1ms,
  input  logic       iPWRDN_REQ,
  input  logic       iFAULT_REQ,
  input  logic       iPWRGD_P12V_Nodex,
  input  logic       iPWRGD_P12V_AUX_FAN,
  output logic       oHost_PERST_N,
  output logic       oNODEX_EN_GATE,
  output logic       oDEV_EN_GATE,
  output logic       oFAN_EN_GATE,
  output logic       oBusy,
  output logic       oDone,
  output logic       oNODEX_DN_FLT,
  output logic       oFAN_DN_FLT,
  output logic [3:0] oDBG_PWRDN_FSM
);

  localparam logic [3:0] ST_IDLE      = 4'h0;
  localparam logic [3:0] ST_PERST     = 4'h1;
  localparam logic [3:0] ST_NODEX_OFF = 4'h2;
  localparam logic [3:0] ST_DEV_OFF   = 4'h3;
  localparam logic [3:0] ST_FAN_OFF   = 4'h4;
  localparam logic [3:0] ST_DONE      = 4'h5;
  localparam logic [3:0] ST_FAULT     = 4'hF;

  logic [3:0]  r_state;
  logic [15:0] r_cnt;
  logic        r_perst_n;
  logic        r_nodex_gate;
  logic        r_dev_gate;
  logic        r_fan_gate;
  logic        r_busy;
  logic        r_done;
  logic        r_nodex_flt;

  logic [3:0]  w_nxt_state;
  logic        w_nxt_nodex_flt;
  logic        w_state_chg;
  logic        w_nxt_perst_n;
  logic        w_nxt_nodex_gate;
  logic        w_nxt_dev_gate;
  logic        w_nxt_fan_gate;
  logic        w_nxt_busy;
  logic        w_nxt_done;

`ifndef PWR_DN_FAN_KEEP_EN
  logic        r_fan_flt;
  logic        w_nxt_fan_flt;
`else
  // The fan PWRGD is not monitored when the fan rail is kept alive.
  logic        w_unused_fan_pwrgd;
  assign w_unused_fan_pwrgd = iPWRGD_P12V_AUX_FAN;
`endif

  // Next-state and sticky flag decision; fault pre-empts everything but itself.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_nxt_state     = r_state;
    w_nxt_nodex_flt = r_nodex_flt;
`ifndef PWR_DN_FAN_KEEP_EN
    w_nxt_fan_flt   = r_fan_flt;
`endif
    if (iFAULT_REQ && (r_state != ST_FAULT)) begin
      w_nxt_state = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iPWRDN_REQ) begin
            w_nxt_state     = ST_PERST;
            w_nxt_nodex_flt = 1'b0;
`ifndef PWR_DN_FAN_KEEP_EN
            w_nxt_fan_flt   = 1'b0;
`endif
          end
        end
        ST_PERST: begin
          if (r_cnt >= PERST_DLY_MS) w_nxt_state = ST_NODEX_OFF;
        end
        ST_NODEX_OFF: begin
          // PWRGD having fallen wins over a coincident timeout.
          if (!iPWRGD_P12V_Nodex) begin
            w_nxt_state = ST_DEV_OFF;
          end else if (r_cnt >= PGOOD_TMO_MS) begin
            w_nxt_state     = ST_DEV_OFF;
            w_nxt_nodex_flt = 1'b1;
          end
        end
        ST_DEV_OFF: begin
`ifndef PWR_DN_FAN_KEEP_EN
          if (r_cnt >= DEV_DLY_MS) w_nxt_state = ST_FAN_OFF;
`else
          if (r_cnt >= DEV_DLY_MS) w_nxt_state = ST_DONE;
`endif
        end
`ifndef PWR_DN_FAN_KEEP_EN
        ST_FAN_OFF: begin
          if (!iPWRGD_P12V_AUX_FAN) begin
            w_nxt_state = ST_DONE;
          end else if (r_cnt >= PGOOD_TMO_MS) begin
            w_nxt_state   = ST_DONE;
            w_nxt_fan_flt = 1'b1;
          end
        end
`endif
        ST_DONE: begin
          if (!iPWRDN_REQ) w_nxt_state = ST_IDLE;
        end
        ST_FAULT: begin
          if (!iFAULT_REQ && !iPWRDN_REQ) w_nxt_state = ST_IDLE;
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state, so registered outputs change on the
  // same edge as the state. Gates fall progressively and stay low to ST_IDLE.
  always_comb begin
    w_nxt_perst_n    = (w_nxt_state == ST_IDLE);
    w_nxt_nodex_gate = (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_PERST);
    w_nxt_dev_gate   = w_nxt_nodex_gate || (w_nxt_state == ST_NODEX_OFF);
`ifndef PWR_DN_FAN_KEEP_EN
    w_nxt_fan_gate   = w_nxt_dev_gate || (w_nxt_state == ST_DEV_OFF);
`else
    w_nxt_fan_gate   = (w_nxt_state != ST_FAULT);
`endif
    w_nxt_busy       = (w_nxt_state >= ST_PERST) && (w_nxt_state <= ST_FAN_OFF);
    w_nxt_done       = (w_nxt_state == ST_DONE);
  end

  assign w_state_chg = (w_nxt_state != r_state);

  // State, dwell counter and registered outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 16'd0;
      r_perst_n    <= 1'b1;
      r_nodex_gate <= 1'b1;
      r_dev_gate   <= 1'b1;
      r_fan_gate   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_nodex_flt  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state      <= w_nxt_state;
      r_perst_n    <= w_nxt_perst_n;
      r_nodex_gate <= w_nxt_nodex_gate;
      r_dev_gate   <= w_nxt_dev_gate;
      r_fan_gate   <= w_nxt_fan_gate;
      r_busy       <= w_nxt_busy;
      r_done       <= w_nxt_done;
      r_nodex_flt  <= w_nxt_nodex_flt;
      // A tick landing on a state change is dropped: the new state starts at 0.
      if (w_state_chg) begin
        r_cnt <= 16'd0;
      end else if (iTick_1ms && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

`ifndef PWR_DN_FAN_KEEP_EN
  // Sticky fan power-down fault flag.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_fan_flt <= 1'b0;
    else         r_fan_flt <= w_nxt_fan_flt;
  end
  assign oFAN_DN_FLT = r_fan_flt;
`else
  assign oFAN_DN_FLT = 1'b0;
`endif

  assign oHost_PERST_N  = r_perst_n;
  assign oNODEX_EN_GATE = r_nodex_gate;
  assign oDEV_EN_GATE   = r_dev_gate;
  assign oFAN_EN_GATE   = r_fan_gate;
  assign oBusy          = r_busy;
  assign oDone          = r_done;
  assign oNODEX_DN_FLT  = r_nodex_flt;
  assign oDBG_PWRDN_FSM = r_state;

endmodule

// File: tb/tb_pwr_dn_seq.sv
// ---------------------------------------------------------------------------
// tb_pwr_dn_seq
// Directed bench for pwr_dn_seq with default delays. The 1 ms tick is
// compressed to one pulse every 4 clocks to keep runs short; dwell windows
// are expressed in clocks from that ratio. Honours PWR_DN_FAN_KEEP_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwr_dn_seq;

  localparam int TICK_DIV = 4;

  // Packed observation: {PERST_N, NODEX, DEV, FAN, BUSY, DONE, NFLT, FFLT, STATE}
  localparam logic [11:0] V_IDLE  = 12'hF00;
  localparam logic [11:0] V_PERST = 12'h781;
  localparam logic [11:0] V_NODEX = 12'h382;
  localparam logic [11:0] V_DEV   = 12'h183;
  localparam logic [11:0] V_FAN   = 12'h084;
  localparam logic [11:0] V_FAULT = 12'h00F;
  localparam logic [11:0] V_NFLT  = 12'h020;
`ifndef PWR_DN_FAN_KEEP_EN
  localparam logic [11:0] V_DONE  = 12'h045;
`else
  localparam logic [11:0] V_DONE  = 12'h145;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       pwrdn_req;
  logic       fault_req;
  logic       pg_nodex;
  logic       pg_fan;
  logic       perst_n, nodex_gate, dev_gate, fan_gate, busy, done, nflt, fflt;
  logic [3:0] fsm;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;
  int tcnt   = 0;
  int n;
  logic saw_fan_state = 1'b0;

  pwr_dn_seq dut (
    .iClk                (clk),
    .iRst_n              (rst_n),
    .iTick_1ms           (tick),
    .iPWRDN_REQ          (pwrdn_req),
    .iFAULT_REQ          (fault_req),
    .iPWRGD_P12V_Nodex   (pg_nodex),
    .iPWRGD_P12V_AUX_FAN (pg_fan),
    .oHost_PERST_N       (perst_n),
    .oNODEX_EN_GATE      (nodex_gate),
    .oDEV_EN_GATE        (dev_gate),
    .oFAN_EN_GATE        (fan_gate),
    .oBusy               (busy),
    .oDone               (done),
    .oNODEX_DN_FLT       (nflt),
    .oFAN_DN_FLT         (fflt),
    .oDBG_PWRDN_FSM      (fsm)
  );

  assign obs = {perst_n, nodex_gate, dev_gate, fan_gate, busy, done, nflt, fflt, fsm};

  always #250 clk = ~clk;

  // Compressed 1 ms tick, one clock wide, driven away from the active edge.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt + 1) % TICK_DIV;
      tick = (tcnt == 0);
    end
  end

  always @(negedge clk) if (fsm == 4'h4) saw_fan_state <= 1'b1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
    end
  endtask

  // Wait (bounded) for a state code; n returns negedges elapsed.
  task automatic wait_state(input logic [3:0] code, input int budget,
                            input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((fsm != code) && (cyc < budget));
    if (fsm != code) check({tag, "_timeout"}, {28'd0, fsm}, {28'd0, code});
  endtask

  // Dwell window in clocks for a D-tick delay measured from the first
  // negedge in the state: [P*(D-1)+2, P*D+1].
  function automatic logic in_win(input int cyc, input int d);
    return (cyc >= TICK_DIV * (d - 1) + 2) && (cyc <= TICK_DIV * d + 1);
  endfunction

  initial begin
    rst_n = 1'b0; pwrdn_req = 1'b0; fault_req = 1'b0;
    pg_nodex = 1'b1; pg_fan = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_vec", obs, V_IDLE);

    // Nominal orderly power-down.
    pwrdn_req = 1'b1;
    @(negedge clk);
    check("req_to_perst", obs, V_PERST);
    wait_state(4'h2, 100, "to_nodex", n);
    check("perst_dly", in_win(n, 10), 1);
    check("nodex_vec", obs, V_NODEX);
    repeat (5 * TICK_DIV) @(negedge clk);
    pg_nodex = 1'b0;
    wait_state(4'h3, 10, "to_dev", n);
    check("nodex_pg_exit", n, 1);
    check("dev_vec", obs, V_DEV);
`ifndef PWR_DN_FAN_KEEP_EN
    wait_state(4'h4, 120, "to_fan", n);
    check("dev_dly", in_win(n, 20), 1);
    check("fan_vec", obs, V_FAN);
    repeat (8 * TICK_DIV) @(negedge clk);
    pg_fan = 1'b0;
    wait_state(4'h5, 10, "to_done", n);
    check("fan_pg_exit", n, 1);
`else
    wait_state(4'h5, 120, "to_done", n);
    check("dev_dly", in_win(n, 20), 1);
`endif
    check("done_vec", obs, V_DONE);
    repeat (5) @(negedge clk);
    check("done_hold", obs, V_DONE);
    pwrdn_req = 1'b0;
    @(negedge clk);
    check("done_to_idle", obs, V_IDLE);

    // Stuck NODEx PWRGD: timeout flag, sequence still completes.
    pg_nodex = 1'b1; pg_fan = 1'b0; pwrdn_req = 1'b1;
    wait_state(4'h2, 100, "stk_nodex", n);
    wait_state(4'h3, 700, "stk_dev", n);
    check("nflt_tmo_dly", in_win(n, 150), 1);
    check("nflt_vec", obs, V_DEV | V_NFLT);
    wait_state(4'h5, 200, "stk_done", n);
    check("nflt_done", obs, V_DONE | V_NFLT);
    pwrdn_req = 1'b0;
    @(negedge clk);
    check("nflt_sticky_idle", obs, V_IDLE | V_NFLT);

    // New request clears the flag; request dropped in ST_PERST still completes.
    pg_nodex = 1'b0;
    pwrdn_req = 1'b1;
    @(negedge clk);
    check("flag_clear", obs, V_PERST);
    pwrdn_req = 1'b0;
    wait_state(4'h5, 300, "drop_done", n);
    check("drop_done_vec", obs, V_DONE);
    @(negedge clk);
    check("drop_to_idle", obs, V_IDLE);

    // Fault in ST_DEV_OFF; request held keeps ST_FAULT.
    pwrdn_req = 1'b1;
    wait_state(4'h3, 100, "flt_dev", n);
    fault_req = 1'b1;
    @(negedge clk);
    check("fault_vec", obs, V_FAULT);
    fault_req = 1'b0;
    repeat (3) @(negedge clk);
    check("fault_hold_req", obs, V_FAULT);
    pwrdn_req = 1'b0;
    @(negedge clk);
    check("fault_exit", obs, V_IDLE);

    // Fault and request together: fault wins.
    fault_req = 1'b1; pwrdn_req = 1'b1;
    @(negedge clk);
    check("fault_wins", obs, V_FAULT);
    fault_req = 1'b0; pwrdn_req = 1'b0;
    @(negedge clk);
    check("fault_wins_exit", obs, V_IDLE);

    // Fault from ST_DONE.
    pwrdn_req = 1'b1;
    wait_state(4'h5, 300, "fdone", n);
    fault_req = 1'b1;
    @(negedge clk);
    check("fault_in_done", obs, V_FAULT);
    fault_req = 1'b0; pwrdn_req = 1'b0;
    @(negedge clk);
    check("fault_done_exit", obs, V_IDLE);

    // Asynchronous reset in ST_NODEX_OFF.
    pg_nodex = 1'b1; pwrdn_req = 1'b1;
    wait_state(4'h2, 100, "rst_nodex", n);
    #10 rst_n = 1'b0;
    #1 check("async_rst", obs, V_IDLE);
    pwrdn_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", obs, V_IDLE);

`ifndef PWR_DN_FAN_KEEP_EN
    check("fan_state_seen", saw_fan_state, 1);
`else
    check("fan_state_skipped", saw_fan_state, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
